// File: rtl/hamming_decode_scheduler.sv
// Two-channel Hamming(7,4) single-error corrector sharing one decode datapath.
// Arbitrates A/B with last-served fairness and keeps saturating per-channel correction counts.
module hamming_decode_scheduler #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             a_valid,
   input  logic [6:0]       a_code,
   output logic             a_ready,
   input  logic             b_valid,
   input  logic [6:0]       b_code,
   output logic             b_ready,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [3:0]       out_data,
   output logic [6:0]       out_code,
   output logic [2:0]       out_syn,
   output logic             out_ch,
   output logic             out_corr,
   input  logic             clr_cnt,
   output logic [CNT_W-1:0] err_cnt_a,
   output logic [CNT_W-1:0] err_cnt_b
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DECODE = 2'd1,
      OUTPUT = 2'd2
   } state_t;

   state_t     state;
   state_t     state_nxt;
   logic [6:0] raw_code;
   logic       raw_ch;
   logic       last_ch;
   logic       grant_a;
   logic       grant_b;
   logic       handshake;
   logic [2:0] syn;
   logic [6:0] flip_mask;
   logic [6:0] fixed_code;

   // On a tie the channel that was not served last wins; last_ch = 1 means B went last.
   assign grant_a   = a_valid && (!b_valid || last_ch);
   assign grant_b   = b_valid && (!a_valid || !last_ch);
   assign handshake = (state == OUTPUT) && out_ready;
   assign out_valid = (state == OUTPUT);

   always_comb begin
      syn[0] = raw_code[0] ^ raw_code[2] ^ raw_code[4] ^ raw_code[6];
      syn[1] = raw_code[1] ^ raw_code[2] ^ raw_code[5] ^ raw_code[6];
      syn[2] = raw_code[3] ^ raw_code[4] ^ raw_code[5] ^ raw_code[6];
      flip_mask = 7'd0;
      for (int k = 0; k < 7; k++) begin
         flip_mask[k] = (syn == 3'(k + 1));
      end
      fixed_code = raw_code ^ flip_mask;
   end

   always_comb begin
      state_nxt = state;
      a_ready   = 1'b0;
      b_ready   = 1'b0;
      case (state)
         IDLE: begin
            if (grant_a) begin
               a_ready   = rst_n;
               state_nxt = DECODE;
            end else if (grant_b) begin
               b_ready   = rst_n;
               state_nxt = DECODE;
            end
         end
         DECODE: state_nxt = OUTPUT;
         OUTPUT: begin
            if (out_ready) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= IDLE;
         last_ch  <= 1'b1;
         raw_code <= 7'd0;
         raw_ch   <= 1'b0;
         out_data <= 4'd0;
         out_code <= 7'd0;
         out_syn  <= 3'd0;
         out_ch   <= 1'b0;
         out_corr <= 1'b0;
      end else begin
         state <= state_nxt;
         if (a_ready || b_ready) begin
            raw_code <= a_ready ? a_code : b_code;
            raw_ch   <= b_ready;
         end
         // Results are frozen here so they stay stable for the whole OUTPUT stall.
         if (state == DECODE) begin
            out_code <= fixed_code;
            out_data <= {fixed_code[6], fixed_code[5], fixed_code[4], fixed_code[2]};
            out_syn  <= syn;
            out_ch   <= raw_ch;
            out_corr <= (syn != 3'd0);
         end
         if (handshake) begin
            last_ch <= out_ch;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n || clr_cnt) begin
         err_cnt_a <= '0;
         err_cnt_b <= '0;
      end else if (handshake && out_corr) begin
         if (!out_ch && !(&err_cnt_a)) begin
            err_cnt_a <= err_cnt_a + CNT_W'(1);
         end
         if (out_ch && !(&err_cnt_b)) begin
            err_cnt_b <= err_cnt_b + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_hamming_decode_scheduler.sv
// Scoreboard bench for hamming_decode_scheduler: a driver predicts grants and queues expected
// results from a positional-XOR Hamming model; a monitor checks outputs and counters every cycle.
module tb_hamming_decode_scheduler;

   localparam int CNT_W   = 2;
   localparam int CNT_MAX = (1 << CNT_W) - 1;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             a_valid;
   logic [6:0]       a_code;
   logic             a_ready;
   logic             b_valid;
   logic [6:0]       b_code;
   logic             b_ready;
   logic             out_valid;
   logic             out_ready;
   logic [3:0]       out_data;
   logic [6:0]       out_code;
   logic [2:0]       out_syn;
   logic             out_ch;
   logic             out_corr;
   logic             clr_cnt;
   logic [CNT_W-1:0] err_cnt_a;
   logic [CNT_W-1:0] err_cnt_b;

   hamming_decode_scheduler #(.CNT_W(CNT_W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .a_valid   (a_valid),
      .a_code    (a_code),
      .a_ready   (a_ready),
      .b_valid   (b_valid),
      .b_code    (b_code),
      .b_ready   (b_ready),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_code  (out_code),
      .out_syn   (out_syn),
      .out_ch    (out_ch),
      .out_corr  (out_corr),
      .clr_cnt   (clr_cnt),
      .err_cnt_a (err_cnt_a),
      .err_cnt_b (err_cnt_b)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       ch;
      logic [6:0] code;
      logic [3:0] data;
      logic [2:0] syn;
      logic       corr;
      int         acc;
   } exp_t;

   exp_t sb[$];
   int   total   = 0;
   int   bad     = 0;
   int   cyc     = 0;
   bit   busy    = 1'b0;
   bit   last_b  = 1'b1;
   bit   mon_en  = 1'b0;
   int   m_cnt_a = 0;
   int   m_cnt_b = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // Syndrome is the XOR of the 1-based positions of all set bits.
   function automatic exp_t model(input logic ch, input logic [6:0] raw, input int acc);
      exp_t       e;
      int         s;
      logic [6:0] fixed;
      s = 0;
      for (int k = 0; k < 7; k++) begin
         if (raw[k]) s = s ^ (k + 1);
      end
      fixed = raw;
      if (s != 0) fixed[s-1] = ~fixed[s-1];
      e.ch   = ch;
      e.code = fixed;
      e.data = {fixed[6], fixed[5], fixed[4], fixed[2]};
      e.syn  = 3'(s);
      e.corr = (s != 0);
      e.acc  = acc;
      return e;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
      end
   endtask

   task automatic applyStimulus(input logic av, input logic [6:0] ac, input logic bv,
                                input logic [6:0] bc, input logic ordy, input logic clr,
                                input logic rstn);
      logic ea;
      logic eb;
      @(negedge clk);
      a_valid   = av;
      a_code    = ac;
      b_valid   = bv;
      b_code    = bc;
      out_ready = ordy;
      clr_cnt   = clr;
      rst_n     = rstn;
      #2;
      if (!mon_en) return;
      ea = 1'b0;
      eb = 1'b0;
      if (rstn && !busy) begin
         if (av && (!bv || last_b)) ea = 1'b1;
         else if (bv) eb = 1'b1;
      end
      checkOutput("a_ready", 32'(a_ready), 32'(ea));
      checkOutput("b_ready", 32'(b_ready), 32'(eb));
      if (ea) begin
         sb.push_back(model(1'b0, ac, cyc));
         busy = 1'b1;
      end else if (eb) begin
         sb.push_back(model(1'b1, bc, cyc));
         busy = 1'b1;
      end
   endtask

   // Monitor: runs after the driver in each cycle, so grant prediction never sees this cycle's handshake.
   always begin
      exp_t e;
      bit   exp_valid;
      bit   hs;
      @(negedge clk);
      #3;
      if (mon_en) begin
         exp_valid = (sb.size() > 0) && (cyc >= sb[0].acc + 2);
         checkOutput("err_cnt_a", 32'(err_cnt_a), 32'(m_cnt_a));
         checkOutput("err_cnt_b", 32'(err_cnt_b), 32'(m_cnt_b));
         checkOutput("out_valid", 32'(out_valid), 32'(exp_valid));
         if (exp_valid && out_valid) begin
            e = sb[0];
            checkOutput("out_ch",   32'(out_ch),   32'(e.ch));
            checkOutput("out_code", 32'(out_code), 32'(e.code));
            checkOutput("out_data", 32'(out_data), 32'(e.data));
            checkOutput("out_syn",  32'(out_syn),  32'(e.syn));
            checkOutput("out_corr", 32'(out_corr), 32'(e.corr));
         end
         if (!rst_n) begin
            sb.delete();
            busy    = 1'b0;
            last_b  = 1'b1;
            m_cnt_a = 0;
            m_cnt_b = 0;
         end else begin
            hs = exp_valid && out_ready;
            if (clr_cnt) begin
               m_cnt_a = 0;
               m_cnt_b = 0;
            end else if (hs && sb[0].corr) begin
               if (!sb[0].ch && m_cnt_a < CNT_MAX) m_cnt_a++;
               if (sb[0].ch && m_cnt_b < CNT_MAX) m_cnt_b++;
            end
            if (hs) begin
               last_b = sb[0].ch;
               void'(sb.pop_front());
               busy = 1'b0;
            end
         end
      end
   end

   initial begin
      logic [6:0] base;
      base = 7'b1010101;
      applyStimulus(0, 0, 0, 0, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 0, 0, 0);
      mon_en = 1'b1;
      applyStimulus(0, 0, 0, 0, 1, 0, 1);
      checkOutput("rst_out_code", 32'(out_code), 0);
      checkOutput("rst_out_data", 32'(out_data), 0);
      checkOutput("rst_out_syn",  32'(out_syn),  0);

      // Clean word then a bit[4] error on channel A.
      applyStimulus(1, base, 0, 0, 1, 0, 1);
      repeat (3) applyStimulus(0, 0, 0, 0, 1, 0, 1);
      applyStimulus(1, 7'b1000101, 0, 0, 1, 0, 1);
      repeat (3) applyStimulus(0, 0, 0, 0, 1, 0, 1);

      // Both channels requesting continuously: strict alternation.
      repeat (13) applyStimulus(1, 7'($urandom), 1, 7'($urandom), 1, 0, 1);

      // Consumer stall while results sit in OUTPUT.
      applyStimulus(1, base ^ 7'h02, 1, base, 0, 0, 1);
      repeat (7) applyStimulus(1, 7'($urandom), 1, 7'($urandom), 0, 0, 1);
      repeat (3) applyStimulus(0, 0, 0, 0, 1, 0, 1);

      // Channel B single-bit errors drive its counter into saturation.
      for (int i = 0; i < 6; i++) begin
         applyStimulus(0, 0, 1, base ^ (7'd1 << $urandom_range(0, 6)), 1, 0, 1);
         applyStimulus(0, 0, 0, 0, 1, 0, 1);
         applyStimulus(0, 0, 0, 0, 1, 0, 1);
      end

      // Clear held through a correcting handshake.
      applyStimulus(1, base ^ 7'h40, 0, 0, 1, 1, 1);
      repeat (3) applyStimulus(0, 0, 0, 0, 1, 1, 1);

      // Reset while a word is in DECODE.
      applyStimulus(1, base ^ 7'h08, 0, 0, 1, 0, 1);
      applyStimulus(0, 0, 0, 0, 1, 0, 0);
      applyStimulus(0, 0, 0, 0, 1, 0, 1);
      checkOutput("rst_decode_valid", 32'(out_valid), 0);

      for (int i = 0; i < 400; i++) begin
         applyStimulus(1'($urandom_range(0, 1)), 7'($urandom), 1'($urandom_range(0, 1)),
                       7'($urandom), 1'($urandom_range(0, 3) != 0),
                       1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 63) != 0));
      end

      repeat (5) applyStimulus(0, 0, 0, 0, 1, 0, 1);
      checkOutput("sb_drained", 32'(sb.size()), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
